// File: rtl/mc_controller_if.sv
// mc_controller_if: control bus between the multicycle control unit and its datapath.
//   Instr      IR[31:12] (cond, op, funct, rn, rd) from the datapath
//   ALUFlags   {N,Z,C,V} produced by the ALU in the current cycle
//   PCWrite, IRWrite, MemWrite, RegWrite   architectural write enables
//   AdrSrc, RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Shift   datapath selects
// master = control unit, slave = datapath.
interface mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUControl;
  logic        Shift;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Shift
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Shift
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: Moore control unit for the multicycle ARMv4-subset core.
// Sequences FETCH/DECODE/... one step per clock, owns the NZCV flag register,
// latches the instruction's condition outcome at the end of DECODE and gates
// every later architectural write with it.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; write enables are held low while asserted
//   bus      mc_controller_if.master (Instr/ALUFlags in, control outputs out)
module mc_controller #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  logic            clk,
  input  logic            reset_n,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condexr_q, condexr_d;

  // IR fields
  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] cmd_s;
  logic       rd_pc_s;
  logic       cond_ex_s;

  // Data-processing decode
  logic [1:0] alu_ctl_s;
  logic       dp_ok_s;
  logic       lsl_s;
  logic       test_s;

  // Unqualified outputs (write enables are gated by reset_n below)
  logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s;
  logic       adr_src_s, alu_src_a_s, shift_s;
  logic [1:0] reg_src_s, imm_src_s, alu_src_b_s, result_src_s, alu_control_s;

  // Standard ARM condition table; cond 1111 is never executed.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_s    = bus.Instr[19:16];
  assign op_s      = bus.Instr[15:14];
  assign funct_s   = bus.Instr[13:8];
  assign cmd_s     = funct_s[4:1];
  assign rd_pc_s   = (bus.Instr[3:0] == 4'd15);
  assign cond_ex_s = cond_eval(cond_s, flags_q);

  // Decode funct[4:1] into ALU operation, validity, LSL and compare-only class
  always_comb begin
    alu_ctl_s = 2'b00;
    dp_ok_s   = 1'b1;
    lsl_s     = 1'b0;
    test_s    = 1'b0;
    case (cmd_s)
      4'b0100: alu_ctl_s = 2'b00;
      4'b0010: alu_ctl_s = 2'b01;
      4'b0000: alu_ctl_s = 2'b10;
      4'b1100: alu_ctl_s = 2'b11;
      4'b1010: begin alu_ctl_s = 2'b01; test_s = 1'b1; end
      4'b1000: begin alu_ctl_s = 2'b10; test_s = 1'b1; end
      4'b1101: begin
        // LSL only exists in register form; the immediate form is a NOP.
        lsl_s   = ~funct_s[5];
        dp_ok_s = ~funct_s[5];
      end
      default: dp_ok_s = 1'b0;
    endcase
  end

  // Next state, flag/condition next values and Moore outputs
  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    condexr_d     = condexr_q;
    pc_write_s    = 1'b0;
    ir_write_s    = 1'b0;
    mem_write_s   = 1'b0;
    reg_write_s   = 1'b0;
    adr_src_s     = 1'b0;
    alu_src_a_s   = 1'b0;
    shift_s       = 1'b0;
    imm_src_s     = 2'b00;
    alu_src_b_s   = 2'b00;
    result_src_s  = 2'b00;
    alu_control_s = 2'b00;
    // RA1=R15 for branches, RA2=rd for stores; IR is stale during FETCH.
    reg_src_s     = {(op_s == 2'b01) & ~funct_s[0], (op_s == 2'b10)};
    case (state_q)
      S_FETCH: begin
        reg_src_s    = 2'b00;
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        condexr_d    = cond_ex_s;
        case (op_s)
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          2'b00:   state_d = funct_s[5] ? S_EXECI : S_EXECR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b_s = 2'b01;
        imm_src_s   = 2'b01;
        state_d     = funct_s[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src_s = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = condexr_q;
        pc_write_s   = condexr_q & rd_pc_s;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        adr_src_s   = 1'b1;
        mem_write_s = condexr_q;
        state_d     = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b_s   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control_s = alu_ctl_s;
        shift_s       = lsl_s;
        if (condexr_q && funct_s[0] && dp_ok_s) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          // C/V only meaningful for the adder; LSL and logic ops keep them.
          if (!alu_ctl_s[1] && !lsl_s) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
          end else begin
            flags_d[1:0] = flags_q[1:0];
          end
        end else begin
          flags_d = flags_q;
        end
        state_d = test_s ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        shift_s     = lsl_s;
        reg_write_s = condexr_q & dp_ok_s;
        pc_write_s  = condexr_q & dp_ok_s & rd_pc_s;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b_s  = 2'b01;
        imm_src_s    = 2'b10;
        result_src_s = 2'b10;
        pc_write_s   = condexr_q;
        state_d      = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, flag and latched-condition registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      flags_q   <= FLAGS_INIT;
      condexr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      condexr_q <= condexr_d;
    end
  end

  // Write enables drop immediately on reset so an aborted instruction commits nothing.
  assign bus.PCWrite    = pc_write_s  & reset_n;
  assign bus.IRWrite    = ir_write_s  & reset_n;
  assign bus.MemWrite   = mem_write_s & reset_n;
  assign bus.RegWrite   = reg_write_s & reset_n;
  assign bus.AdrSrc     = adr_src_s;
  assign bus.RegSrc     = reg_src_s;
  assign bus.ImmSrc     = imm_src_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ResultSrc  = result_src_s;
  assign bus.ALUControl = alu_control_s;
  assign bus.Shift      = shift_s;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARMv4 subset core (ADD, SUB, AND, ORR, CMP, TST, LSL, LDR, STR, B, all condition codes). It replaces the single-cycle decoder and condition logic. A Moore state machine drives a shared-memory multicycle datapath (IR, A/WriteData, ALUOut and Data registers) one step per clock. The block also holds the NZCV flags, latches each instruction's condition outcome, and gates every architectural write with it.

## Interface
- FLAGS_INIT, 4'b0000, NZCV value loaded on reset

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Instr  in  20  IR bits [31:12]: cond, op, funct, rn, rd
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- RegSrc  out  2  [0] RA1 = R15, [1] RA2 = rd (same meaning as the single-cycle core)
- ImmSrc  out  2  00 imm8, 01 imm12, 10 branch imm24<<2
- ALUSrcA  out  1  0 = A register, 1 = PC
- ALUSrcB  out  2  00 = WriteData register, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data register, 10 = ALU result
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Shift  out  1  selects the LSL path (rm << Instr[11:7]) on SrcB and Result

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH
  - AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00 (R15 = PC+8).
  - Next state by op: op=01 → MEMADR; op=10 → BRANCH; op=00 with funct[5]=1 → EXECI; op=00 with funct[5]=0 → EXECR; op=11 → FETCH (NOP).
- MEMADR
  - ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=00.
  - Next state: L=1 → MEMRD; L=0 → MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondExR → FETCH.
- MEMWR: AdrSrc=1, RegSrc[1]=1, MemWrite=CondExR → FETCH.
- EXECR / EXECI
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 with ImmSrc=00 (EXECI); ALUControl from funct[4:1].
  - Next state: CMP/TST → FETCH; otherwise → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondExR; Shift held from EXECR → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ALUControl=00, ResultSrc=10, PCWrite=CondExR → FETCH.
- funct[4:1] decode
  - 0100 ADD → 00; 0010 SUB → 01; 0000 AND → 10; 1100 ORR → 11; 1010 CMP → 01; 1000 TST → 10.
  - 1101 LSL: Shift=1, ALUControl=00. In EXECI, LSL is undefined and treated as NOP.
  - Any other code: NOP, meaning no register or flag write.
- RegWrite cycle: when rd=15 in MEMWB/ALUWB, PCWrite=CondExR in the same cycle (ResultSrc unchanged).
- Condition logic
  - CondEx is combinational from Instr[31:28] and the flag register, using the standard 15-code table; cond 1111 gives 0.
  - CondExR is latched at the end of DECODE and used by every later state of the instruction.
  - A failed condition keeps the state sequence but zeroes every write enable.
- Flags
  - Update at the end of EXECR/EXECI only when S=1 and CondExR=1.
  - NZ update for every ALU op; CV update only when ALUControl is 00 or 01 (ADD, SUB, CMP).
  - LSL updates NZ only.

## Timing
- Cycles per instruction: LDR 5; STR 4; DP/LSL 4; CMP/TST 3; B 3; op=11 NOP 2.
- All outputs are a function of state and the IR only (Moore); no output depends combinationally on ALUFlags.
- Reset
  - While reset_n=0: state=FETCH, flags=FLAGS_INIT, CondExR=0, all write enables (PCWrite, IRWrite, MemWrite, RegWrite) forced 0.
  - Selects take their FETCH values while in reset.
  - First FETCH with writes enabled is the first rising edge after reset_n goes high.
- Reset asserted mid-instruction: abort immediately; no pending write completes.
- Flags written in EXECR are visible to the next instruction's DECODE, never to the current instruction's ALUWB (CondExR already latched).

## Test plan
- Reset, then ADD R2,R0,#5 (E2802005): state sequence FETCH, DECODE, EXECI, ALUWB, FETCH; PCWrite=1 only in FETCH; RegWrite=1 only in ALUWB; flags unchanged.
- SUBS R7,R3,R3 (E0537003), then ADDNE R1,R1,#1 (12811001): Z=1 after EXECR; the ADDNE takes 4 cycles with RegWrite=0 in ALUWB.
- CMP R0,R0 (E1500000), then BEQ −2 (0AFFFFFE): CMP returns to FETCH after 3 cycles with Z=1 and C=1; BRANCH asserts PCWrite=1, ResultSrc=10, ImmSrc=10.
- STR R7,[R3,#84] (E5837054): MEMWR asserts MemWrite=1, AdrSrc=1, RegSrc=10; total 4 cycles. LDR R2,[R0,#96] (E5902060): MEMWB asserts ResultSrc=01 and RegWrite=1; total 5 cycles.
- LSL R4,R1,#2 (E1A04101): Shift=1 in EXECR and ALUWB, ALUControl=00. LDR to R15 (E59FF000): MEMWB asserts both RegWrite=1 and PCWrite=1.
- Drop reset_n low during MEMWR of an STR: MemWrite drops to 0 asynchronously; after release the state is FETCH and flags equal FLAGS_INIT.
